// File: rtl/mac_reg_pkg.sv
// mac_reg_pkg: shared types and constants for the MAC register-port arbiter
// Contents: state_t (IDLE/ACCESS/ACK), default address/data widths, timeout read-data pattern.
package mac_reg_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    localparam int MAC_REG_AW = 14;
    localparam int MAC_REG_DW = 32;
    localparam logic [31:0] MAC_REG_TMO_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mac_reg_rr_pick.sv
// mac_reg_rr_pick: combinational round-robin pick, first requester at/after ptr cyclically
// Ports: i_req (request vector), i_ptr (rotation start) -> o_idx (chosen index), o_valid (any request).
module mac_reg_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        // Walk the rotation from farthest to nearest so the nearest pending requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (i_req[j]) o_idx = PW'(j);
        end
    end
endmodule

// File: rtl/mac_reg_arbiter.sv
// mac_reg_arbiter: round-robin sharing of one Avalon-MM MAC register port among NREQ requesters
// Ports: clk, rst_n (async active-low); i_req_rd/i_req_wr/i_req_addr/i_req_writedata from requesters;
//   o_req_ack/o_req_err/o_req_readdata back to them; o_m_addr/o_m_read/o_m_write/o_m_writedata,
//   i_m_waitrequest/i_m_readdata on the MAC side; o_busy high outside IDLE.
// Option: define MAC_REG_TIMEOUT_EN to abort accesses stalled by waitrequest for TMO_CYC cycles.
module mac_reg_arbiter
    import mac_reg_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = MAC_REG_AW,
    parameter int DW      = MAC_REG_DW,
    parameter int TMO_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   i_req_rd,
    input  logic [NREQ-1:0]   i_req_wr,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_writedata,
    output logic [NREQ-1:0]   o_req_ack,
    output logic [NREQ-1:0]   o_req_err,
    output logic [DW-1:0]     o_req_readdata,
    output logic [AW-1:0]     o_m_addr,
    output logic              o_m_read,
    output logic              o_m_write,
    output logic [DW-1:0]     o_m_writedata,
    input  logic              i_m_waitrequest,
    input  logic [DW-1:0]     i_m_readdata,
    output logic              o_busy
);
    localparam int PW = $clog2(NREQ);
    state_t          r_state, w_next;
    logic [PW-1:0]   r_ptr, r_idx, w_idx;
    logic            w_valid, w_tmo, w_done, r_wr, r_err;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata, r_rdata;
    logic            w_grant;
    mac_reg_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .i_req   (i_req_rd | i_req_wr),
        .i_ptr   (r_ptr),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );
    assign w_grant = (r_state == IDLE) && w_valid;
`ifdef MAC_REG_TIMEOUT_EN
    logic [15:0] r_tmo;
    assign w_tmo = (r_state == ACCESS) && i_m_waitrequest && (r_tmo == 16'(TMO_CYC - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= (r_state == ACCESS) ? r_tmo + 16'd1 : '0;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO_CYC < 1);
    assign w_tmo = 1'b0;
`endif
    assign w_done = !i_m_waitrequest || w_tmo;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE)   ? (w_valid ? ACCESS : IDLE) :
                 (r_state == ACCESS) ? (w_done ? ACK : ACCESS) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_idx   <= w_idx;
                r_addr  <= i_req_addr[int'(w_idx)*AW +: AW];
                r_wdata <= i_req_writedata[int'(w_idx)*DW +: DW];
                // A write takes priority when a requester raises both rd and wr.
                r_wr    <= i_req_wr[w_idx];
                r_err   <= 1'b0;
            end
            if (r_state == ACCESS && !i_m_waitrequest && !r_wr) r_rdata <= i_m_readdata;
            if (w_tmo) begin
                r_rdata <= DW'(MAC_REG_TMO_DATA);
                r_err   <= 1'b1;
            end
            if (r_state == ACK) r_ptr <= (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + PW'(1);
        end
    end
    always_comb begin
        o_busy         = (r_state != IDLE);
        o_m_read       = (r_state == ACCESS) && !r_wr;
        o_m_write      = (r_state == ACCESS) && r_wr;
        o_m_addr       = r_addr;
        o_m_writedata  = r_wdata;
        o_req_readdata = r_rdata;
        o_req_ack      = (r_state == ACK) ? (NREQ'(1) << r_idx) : '0;
        o_req_err      = (r_state == ACK && r_err) ? (NREQ'(1) << r_idx) : '0;
    end
endmodule

// File: tb/tb_mac_reg_arbiter.sv
// tb_mac_reg_arbiter: directed self-checking bench for mac_reg_arbiter
module tb_mac_reg_arbiter;
    localparam int NREQ = 2;
    localparam int AW = 14;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0] i_req_rd = '0, i_req_wr = '0;
    logic [NREQ*AW-1:0] i_req_addr = '0;
    logic [NREQ*DW-1:0] i_req_writedata = '0;
    logic [NREQ-1:0] o_req_ack, o_req_err;
    logic [DW-1:0] o_req_readdata, o_m_writedata;
    logic [AW-1:0] o_m_addr;
    logic o_m_read, o_m_write, o_busy;
    logic i_m_waitrequest = 1'b0;
    logic [DW-1:0] i_m_readdata = '0;
    int total = 0, bad = 0;
    int n_mw = 0, n_mr = 0, n_ack = 0;
    mac_reg_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_rd(i_req_rd), .i_req_wr(i_req_wr),
        .i_req_addr(i_req_addr), .i_req_writedata(i_req_writedata),
        .o_req_ack(o_req_ack), .o_req_err(o_req_err), .o_req_readdata(o_req_readdata),
        .o_m_addr(o_m_addr), .o_m_read(o_m_read), .o_m_write(o_m_write),
        .o_m_writedata(o_m_writedata), .i_m_waitrequest(i_m_waitrequest),
        .i_m_readdata(i_m_readdata), .o_busy(o_busy)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (o_m_write) n_mw++;
        if (o_m_read) n_mr++;
        if (|o_req_ack) n_ack++;
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_ack(input int lim, output bit got);
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            step();
            if (|o_req_ack) got = 1'b1;
        end
    endtask
    initial begin
        bit got;
        int mw0, mr0, ack0;
        logic [NREQ-1:0] acked;
        step();
        step();
        check("rst_busy", o_busy, 0);
        check("rst_strobes", {o_m_read, o_m_write}, 0);
        check("rst_ack_err", {o_req_ack, o_req_err}, 0);
        check("rst_rdata", o_req_readdata, 0);
        check("rst_addr", o_m_addr, 0);
        rst_n = 1'b1;
        step();
        // 1: single write, waitrequest released on the 4th strobe cycle
        mw0 = n_mw; ack0 = n_ack;
        i_req_addr[0 +: AW] = 14'h002;
        i_req_writedata[0 +: DW] = 32'h0000_0043;
        i_req_wr = 2'b01;
        i_m_waitrequest = 1'b1;
        step();
        check("t1_mwrite", o_m_write, 1);
        check("t1_mread", o_m_read, 0);
        check("t1_addr", o_m_addr, 14'h002);
        check("t1_wdata", o_m_writedata, 32'h43);
        check("t1_busy", o_busy, 1);
        step();
        step();
        step();
        check("t1_still_access", o_m_write, 1);
        i_m_waitrequest = 1'b0;
        step();
        check("t1_ack", o_req_ack, 2'b01);
        check("t1_err", o_req_err, 0);
        check("t1_strobe_drop", o_m_write, 0);
        i_req_wr = 2'b00;
        step();
        check("t1_idle", o_busy, 0);
        check("t1_write_cycles", n_mw - mw0, 4);
        check("t1_ack_count", n_ack - ack0, 1);
        // 2: single read from requester 1
        i_req_addr[AW +: AW] = 14'h003;
        i_m_readdata = 32'h1234_5678;
        i_req_rd = 2'b10;
        step();
        check("t2_mread", o_m_read, 1);
        check("t2_mwrite", o_m_write, 0);
        check("t2_addr", o_m_addr, 14'h003);
        step();
        check("t2_ack", o_req_ack, 2'b10);
        check("t2_rdata", o_req_readdata, 32'h1234_5678);
        i_req_rd = 2'b00;
        i_m_readdata = 32'h0;
        step();
        // 3: contention, ptr back at 0 -> grants alternate 0,1,0,1
        i_req_rd = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ack(10, got);
            check("t3_ack_seen", got, 1);
            acked = o_req_ack;
            check("t3_grant_order", acked, (g % 2 == 0) ? 2'b01 : 2'b10);
            i_req_rd = i_req_rd & ~acked;
            step();
            if (g < 3) i_req_rd = i_req_rd | acked;
        end
        i_req_rd = 2'b00;
        step();
        // 4: rd+wr together on requester 0 -> one write, no read
        mw0 = n_mw; mr0 = n_mr;
        i_req_addr[0 +: AW] = 14'h005;
        i_req_writedata[0 +: DW] = 32'hA5;
        i_req_rd = 2'b01;
        i_req_wr = 2'b01;
        wait_ack(10, got);
        check("t4_ack_seen", got, 1);
        check("t4_ack", o_req_ack, 2'b01);
        i_req_rd = 2'b00;
        i_req_wr = 2'b00;
        step();
        check("t4_writes", n_mw - mw0, 1);
        check("t4_reads", n_mr - mr0, 0);
        // 5: reset in the middle of a stalled read
        i_req_rd = 2'b10;
        i_m_waitrequest = 1'b1;
        step();
        check("t5_mread_before", o_m_read, 1);
        ack0 = n_ack;
        #2 rst_n = 1'b0;
        #1;
        check("t5_mread_async_drop", o_m_read, 0);
        check("t5_busy_drop", o_busy, 0);
        i_req_rd = 2'b00;
        i_m_waitrequest = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        check("t5_no_ack", n_ack - ack0, 0);
        i_req_addr[0 +: AW] = 14'h007;
        i_req_writedata[0 +: DW] = 32'h77;
        i_req_wr = 2'b01;
        wait_ack(10, got);
        check("t5_after_reset_ack", got, 1);
        check("t5_after_reset_which", o_req_ack, 2'b01);
        i_req_wr = 2'b00;
        step();
        // 6: waitrequest stuck high
        mr0 = n_mr; ack0 = n_ack;
        i_req_addr[0 +: AW] = 14'h009;
        i_req_rd = 2'b01;
        i_m_waitrequest = 1'b1;
`ifdef MAC_REG_TIMEOUT_EN
        wait_ack(40, got);
        check("t6_tmo_ack_seen", got, 1);
        check("t6_tmo_err", o_req_err, 2'b01);
        check("t6_tmo_rdata", o_req_readdata, 32'hDEAD_BEEF);
        check("t6_tmo_strobe_cycles", n_mr - mr0, 16);
        i_req_rd = 2'b00;
        i_m_waitrequest = 1'b0;
        step();
        check("t6_idle", o_busy, 0);
`else
        for (int i = 0; i < 2000; i++) step();
        check("t6_no_ack", n_ack - ack0, 0);
        check("t6_still_reading", o_m_read, 1);
        check("t6_err_tied", o_req_err, 0);
        rst_n = 1'b0;
        i_req_rd = 2'b00;
        i_m_waitrequest = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("t6_idle_after_reset", o_busy, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
